reg_transfer_engine: RTL and testbench

//  Parametrised register-transfer datapath: a register file plus a queued micro-op engine.

---
 rtl/dataflow_pkg.sv | 48 ++++
 rtl/cmd_fifo.sv | 65 ++++++
 rtl/reg_transfer_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_reg_transfer_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// -----------------------------------------------------------------------------
// dataflow_pkg
//   Shared types for the register-transfer engine: opcode and FSM enumerations,
//   the queued command record, and small opcode-class helpers.
//
//   cmd_t index fields are CMD_IDX_W bits wide, which is enough for any
//   NUM_REGS up to 2**CMD_IDX_W - 1. Narrower port indices are zero-extended
//   into them when a command is queued.
// -----------------------------------------------------------------------------
package dataflow_pkg;

  localparam int CMD_IDX_W = 8;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_MOVE    = 3'd1,
    OP_INC16   = 3'd2,
    OP_DEC16   = 3'd3,
    OP_SET_FF  = 3'd4,
    OP_SET_00  = 3'd5,
    OP_STORE   = 3'd6,
    OP_CLR_ERR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CARRY = 2'd2
  } xfer_state_e;

  typedef struct packed {
    op_e                  op;
    logic [CMD_IDX_W-1:0] src;
    logic [CMD_IDX_W-1:0] dst;
  } cmd_t;

  // Opcodes whose destination index must name a real register.
  function automatic logic op_writes_reg(input op_e op);
    return (op == OP_MOVE)   || (op == OP_INC16)  || (op == OP_DEC16) ||
           (op == OP_SET_FF) || (op == OP_SET_00);
  endfunction

  // Opcodes that operate on the register pair {dst+1, dst}.
  function automatic logic op_is_pair(input op_e op);
    return (op == OP_INC16) || (op == OP_DEC16);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
//   Synchronous single-clock FIFO for queued transfer commands. Pointers are
//   one bit wider than log2(DEPTH) so full and empty are distinguishable
//   without a separate counter. DEPTH must be a power of 2 and >= 2.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (empties the FIFO)
//   push_i    in   write din_i (ignored when full)
//   din_i     in   entry to write
//   pop_i     in   discard the head entry (ignored when empty)
//   dout_o    out  head entry (valid while !empty_o)
//   full_o    out  DEPTH entries held
//   empty_o   out  no entries held
//   count_o   out  number of entries held
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter  int WIDTH_CMD = 8,
  parameter  int DEPTH     = 4,
  localparam int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH_CMD-1:0] din_i,
  input  logic                 pop_i,
  output logic [WIDTH_CMD-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [PTR_W-1:0]     count_o
);

  localparam int AW = PTR_W - 1;

  logic [WIDTH_CMD-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic                 push_ok;
  logic                 pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == PTR_W'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, so resetting it would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/reg_transfer_engine.sv
// -----------------------------------------------------------------------------
// reg_transfer_engine
//   Register file plus a queued micro-op engine. Commands enter through a
//   valid/ready FIFO and retire one per cycle in order. INC16/DEC16 operate on
//   the pair {reg[dst+1], reg[dst]}; when the low half wraps, the high half is
//   updated in a separate CARRY cycle that raises page_cross.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  FIFO can accept (low during reset and when full)
//   cmd_op      in   opcode (op_e)
//   cmd_src     in   source index; NUM_REGS selects ext_data
//   cmd_dst     in   destination index / low index of a pair
//   ext_data    in   external data, sampled when its MOVE/STORE executes
//   rd_idx      in   debug read select
//   rd_data     out  reg[rd_idx], or 0 when rd_idx >= NUM_REGS
//   addr_out    out  {reg[ADDR_HI], reg[ADDR_LO]}
//   data_out    out  output data register
//   page_cross  out  high during the CARRY cycle of a pair op
//   busy        out  commands queued or a CARRY cycle pending
//   err         out  sticky error flag
// -----------------------------------------------------------------------------
module reg_transfer_engine
  import dataflow_pkg::*;
#(
  parameter  int               WIDTH      = 8,
  parameter  int               NUM_REGS   = 8,
  parameter  int               FIFO_DEPTH = 4,
  parameter  int               ADDR_LO    = 0,
  parameter  int               ADDR_HI    = 1,
  parameter  logic [WIDTH-1:0] RESET_VAL  = '0,
  localparam int               IDXW       = $clog2(NUM_REGS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IDXW-1:0]    cmd_src,
  input  logic [IDXW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0]   ext_data,
  input  logic [IDXW-1:0]    rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic [2*WIDTH-1:0] addr_out,
  output logic [WIDTH-1:0]   data_out,
  output logic               page_cross,
  output logic               busy,
  output logic               err
);

  localparam int                   PTR_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int                   CMD_W        = $bits(cmd_t);
  localparam logic [CMD_IDX_W-1:0] EXT_IDX      = CMD_IDX_W'(NUM_REGS);
  localparam logic [CMD_IDX_W:0]   EXT_IDX_WIDE = (CMD_IDX_W + 1)'(NUM_REGS);
  localparam logic [WIDTH-1:0]     ONE          = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     regs_q [NUM_REGS];
  xfer_state_e          state_q, state_d;
  logic [CMD_IDX_W-1:0] carry_idx_q, carry_idx_d;   // high index of the pending pair
  logic                 carry_dec_q, carry_dec_d;   // pending op is a borrow
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 err_q, err_d;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             cmd_in;
  cmd_t             head;
  logic [CMD_W-1:0] head_bits;
  logic             push;
  logic             exec;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W-1:0] fifo_count;
  logic             next_nonempty;

  // Ready is forced low during reset so nothing can be pushed into a FIFO
  // that is being emptied on the same edge.
  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    cmd_in.op  = op_e'(cmd_op);
    cmd_in.src = CMD_IDX_W'(cmd_src);
    cmd_in.dst = CMD_IDX_W'(cmd_dst);
  end

  cmd_fifo #(
    .WIDTH_CMD (CMD_W),
    .DEPTH     (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (cmd_in),
    .pop_i   (exec),
    .dout_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head = cmd_t'(head_bits);

  // The head executes on any edge where it exists and no CARRY is pending;
  // a command pushed on one edge therefore executes on the next.
  assign exec = (state_q != ST_CARRY) && !fifo_empty;

  // Occupancy after this edge, used to decide EXEC vs IDLE.
  assign next_nonempty = push ||
                         (fifo_count > PTR_W'(1)) ||
                         ((fifo_count == PTR_W'(1)) && !exec);

  // ---------------------------------------------------------------------------
  // Operand fetch
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    src_val = '0;
    lo_val  = '0;
    hi_val  = '0;
    if (head.src == EXT_IDX) src_val = ext_data;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (head.src   == CMD_IDX_W'(i)) src_val = regs_q[i];
      if (head.dst   == CMD_IDX_W'(i)) lo_val  = regs_q[i];
      if (carry_idx_q == CMD_IDX_W'(i)) hi_val  = regs_q[i];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) rd_data = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Decode and error detection
  // ---------------------------------------------------------------------------
  logic [CMD_IDX_W:0] dst_p1;   // one bit wider so dst+1 cannot wrap
  logic               cmd_err;

  assign dst_p1  = {1'b0, head.dst} + (CMD_IDX_W + 1)'(1);
  assign cmd_err = (head.src > EXT_IDX) ||
                   (op_writes_reg(head.op) && (head.dst >= EXT_IDX)) ||
                   (op_is_pair(head.op) && (dst_p1 >= EXT_IDX_WIDE));

  // ---------------------------------------------------------------------------
  // Execute / next state
  // ---------------------------------------------------------------------------
  // At most one register is written per cycle: either the executing command
  // or the deferred high-half update of a CARRY cycle.
  logic                 wr_en;
  logic [CMD_IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0]     wr_data;
  logic                 carry_start;

  always_comb begin
    wr_en       = 1'b0;
    wr_idx      = head.dst;
    wr_data     = '0;
    carry_start = 1'b0;
    carry_idx_d = carry_idx_q;
    carry_dec_d = carry_dec_q;
    data_out_d  = data_out_q;
    err_d       = err_q;

    if (state_q == ST_CARRY) begin
      wr_en   = 1'b1;
      wr_idx  = carry_idx_q;
      wr_data = carry_dec_q ? (hi_val - ONE) : (hi_val + ONE);
    end else if (exec) begin
      // A CLR_ERR that is itself malformed still clears: clear wins.
      if (head.op == OP_CLR_ERR) err_d = 1'b0;
      else if (cmd_err)          err_d = 1'b1;

      if (!cmd_err) begin
        case (head.op)
          OP_MOVE: begin
            wr_en   = 1'b1;
            wr_data = src_val;
          end
          OP_INC16: begin
            wr_en       = 1'b1;
            wr_data     = lo_val + ONE;
            carry_start = (lo_val == '1);
            carry_idx_d = dst_p1[CMD_IDX_W-1:0];
            carry_dec_d = 1'b0;
          end
          OP_DEC16: begin
            wr_en       = 1'b1;
            wr_data     = lo_val - ONE;
            carry_start = (lo_val == '0);
            carry_idx_d = dst_p1[CMD_IDX_W-1:0];
            carry_dec_d = 1'b1;
          end
          OP_SET_FF: begin
            wr_en   = 1'b1;
            wr_data = '1;
          end
          OP_SET_00: begin
            wr_en   = 1'b1;
            wr_data = '0;
          end
          OP_STORE: data_out_d = src_val;
          default: ;
        endcase
      end
    end

    if (carry_start)        state_d = ST_CARRY;
    else if (next_nonempty) state_d = ST_EXEC;
    else                    state_d = ST_IDLE;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values that existed before this edge.
  // The register file is architectural state with a defined reset value, so
  // unlike the FIFO storage it is reset. Reset also wins over a pending CARRY
  // write, which aborts that pair op with the high half left at RESET_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      state_q     <= ST_IDLE;
      carry_idx_q <= '0;
      carry_dec_q <= 1'b0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_idx == CMD_IDX_W'(i))) regs_q[i] <= wr_data;
      end
      state_q     <= state_d;
      carry_idx_q <= carry_idx_d;
      carry_dec_q <= carry_dec_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign addr_out   = {regs_q[ADDR_HI], regs_q[ADDR_LO]};
  assign data_out   = data_out_q;
  assign err        = err_q;
  assign page_cross = (state_q == ST_CARRY);
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_transfer_engine.sv
// -----------------------------------------------------------------------------
// tb_reg_transfer_engine
//   Directed bench for reg_transfer_engine with default parameters
//   (WIDTH 8, NUM_REGS 8, FIFO_DEPTH 4, addr pair r1:r0, RESET_VAL 0).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_reg_transfer_engine;
  import dataflow_pkg::*;

  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 8;
  localparam int IDXW     = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op    = '0;
  logic [IDXW-1:0]  cmd_src   = '0;
  logic [IDXW-1:0]  cmd_dst   = '0;
  logic [WIDTH-1:0] ext_data  = '0;
  logic [IDXW-1:0]  rd_idx    = '0;
  logic [WIDTH-1:0] rd_data;
  logic [15:0]      addr_out;
  logic [WIDTH-1:0] data_out;
  logic             page_cross;
  logic             busy;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;
  int pc_cnt  = 0;   // page_cross pulses seen, sampled on falling edges

  always #5 clk = ~clk;

  always @(negedge clk) if (page_cross === 1'b1) pc_cnt++;

  reg_transfer_engine #(
    .WIDTH      (WIDTH),
    .NUM_REGS   (NUM_REGS),
    .FIFO_DEPTH (4),
    .ADDR_LO    (0),
    .ADDR_HI    (1),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .ext_data   (ext_data),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .page_cross (page_cross),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    rd_idx = IDXW'(idx);
    #1;
    check(tag, rd_data, exp);
  endtask

  // Present one command for exactly one edge.
  task automatic issue(input op_e op, input int src, input int dst);
    cmd_op    = op;
    cmd_src   = IDXW'(src);
    cmd_dst   = IDXW'(dst);
    cmd_valid = 1'b1;
    check("issue_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      tick();
      k++;
    end
    check("drain_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pc_base;
    int   first_block;
    int   wait_cnt;
    op_e  seq [8];

    // ---------------- 1: reset ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", cmd_ready, 0);
    check("busy_in_reset", busy, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);
    for (int i = 0; i <= NUM_REGS; i++) check_reg($sformatf("reset_r%0d", i), i, 8'h00);
    check_reg("rd_out_of_range", 15, 8'h00);
    check("reset_addr", addr_out, 16'h0000);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    check("reset_dout", data_out, 8'h00);
    check("reset_pc", page_cross, 0);
    tick();

    // ---------------- 2: MOVE ext -> r3, STORE r3 back to back ----------------
    ext_data = 8'h5A;
    issue(OP_MOVE, NUM_REGS, 3);
    check("move_queued_busy", busy, 1);
    check_reg("move_not_yet", 3, 8'h00);
    issue(OP_STORE, 3, 0);
    check_reg("move_r3", 3, 8'h5A);
    check("store_not_yet", data_out, 8'h00);
    tick();
    check("store_dout", data_out, 8'h5A);
    check("store_done_idle", busy, 0);

    // ---------------- 3: INC16 with and without carry ----------------
    ext_data = 8'hFF;
    issue(OP_MOVE, NUM_REGS, 0);
    drain();
    ext_data = 8'h12;
    issue(OP_MOVE, NUM_REGS, 1);
    drain();
    check("pair_loaded", addr_out, 16'h12FF);
    pc_base = pc_cnt;
    issue(OP_INC16, 0, 0);
    check("inc_queued_pc", page_cross, 0);
    tick();
    check("inc_carry_pc", page_cross, 1);
    check("inc_low_first", addr_out, 16'h1200);
    check("inc_carry_busy", busy, 1);
    tick();
    check("inc_after_pc", page_cross, 0);
    check("inc_carry_addr", addr_out, 16'h1300);
    check("inc_carry_idle", busy, 0);
    check("inc_one_pulse", pc_cnt - pc_base, 1);

    ext_data = 8'h34;
    issue(OP_MOVE, NUM_REGS, 0);
    drain();
    ext_data = 8'h12;
    issue(OP_MOVE, NUM_REGS, 1);
    drain();
    pc_base = pc_cnt;
    issue(OP_INC16, 0, 0);
    tick();
    check("inc_nc_addr", addr_out, 16'h1235);
    check("inc_nc_pc", page_cross, 0);
    check("inc_nc_idle", busy, 0);
    check("inc_nc_pulses", pc_cnt - pc_base, 0);

    // ---------------- 4: pair wrap both ways ----------------
    issue(OP_SET_00, 0, 0);
    issue(OP_SET_00, 0, 1);
    drain();
    check("pair_zero", addr_out, 16'h0000);
    issue(OP_DEC16, 0, 0);
    tick();
    check("dec_borrow_pc", page_cross, 1);
    check("dec_low_first", addr_out, 16'h00FF);
    tick();
    check("dec_wrap_addr", addr_out, 16'hFFFF);
    check("dec_after_pc", page_cross, 0);
    issue(OP_INC16, 0, 0);
    tick();
    check("inc_wrap_pc", page_cross, 1);
    check("inc_wrap_low", addr_out, 16'hFF00);
    tick();
    check("inc_wrap_addr", addr_out, 16'h0000);
    check("inc_wrap_no_err", err, 0);

    // ---------------- 5: fill the FIFO behind CARRY ops ----------------
    // Alternating INC16/DEC16 on pair r3:r2 starting at 40FF: every op carries,
    // so each takes two cycles and the queue fills while pushing every cycle.
    ext_data = 8'h40;
    issue(OP_SET_FF, 0, 2);
    issue(OP_MOVE, NUM_REGS, 3);
    drain();
    check_reg("fill_r2_init", 2, 8'hFF);
    check_reg("fill_r3_init", 3, 8'h40);
    seq = '{OP_INC16, OP_DEC16, OP_INC16, OP_DEC16, OP_INC16, OP_DEC16, OP_INC16, OP_STORE};
    pc_base     = pc_cnt;
    first_block = -1;
    for (int k = 0; k < 8; k++) begin
      cmd_op    = seq[k];
      cmd_src   = (seq[k] == OP_STORE) ? IDXW'(3) : IDXW'(0);
      cmd_dst   = IDXW'(2);
      cmd_valid = 1'b1;
      wait_cnt  = 0;
      while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
        if (first_block < 0) first_block = k;
        tick();
        wait_cnt++;
      end
      check("fill_push_ready", cmd_ready, 1);
      tick();
    end
    cmd_valid = 1'b0;
    // Four queued with a pop due on the next edge: still not ready.
    check("full_ready_low", cmd_ready, 0);
    check("full_busy", busy, 1);
    check("first_stall_at", first_block, 7);
    drain();
    check_reg("fill_r2_final", 2, 8'h00);
    check_reg("fill_r3_final", 3, 8'h41);
    check("fill_store", data_out, 8'h41);
    check("fill_pulses", pc_cnt - pc_base, 7);
    check("fill_no_err", err, 0);

    // ---------------- 6: errors and reset during CARRY ----------------
    issue(OP_MOVE, 3, NUM_REGS);
    drain();
    check("bad_dst_err", err, 1);
    check_reg("bad_dst_r3", 3, 8'h41);
    check("bad_dst_addr", addr_out, 16'h0000);
    pc_base = pc_cnt;
    issue(OP_INC16, 0, NUM_REGS - 1);
    tick();
    check("bad_pair_single_cycle", busy, 0);
    check("bad_pair_err", err, 1);
    check_reg("bad_pair_r7", NUM_REGS - 1, 8'h00);
    check("bad_pair_no_pulse", pc_cnt - pc_base, 0);
    issue(OP_CLR_ERR, 0, 0);
    drain();
    check("clr_err", err, 0);
    issue(OP_STORE, 9, 0);
    drain();
    check("bad_src_err", err, 1);
    check("bad_src_dout", data_out, 8'h41);
    issue(OP_CLR_ERR, 9, 0);
    drain();
    check("clr_wins", err, 0);

    issue(OP_SET_FF, 0, 0);
    drain();
    check("pre_abort_addr", addr_out, 16'h00FF);
    issue(OP_INC16, 0, 0);
    tick();
    check("abort_in_carry", page_cross, 1);
    rst = 1'b1;
    tick();
    check_reg("abort_r1", 1, 8'h00);
    check("abort_pc", page_cross, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("abort_addr", addr_out, 16'h0000);
    check("abort_ready_after", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
